visor_code_gate: RTL
====================

VISOR_CODE_GATE -- requirements
Module: visor_code_gate

Interface
REQ-001 SHALL provide parameter INJ_DEPTH, default 4, depth of the injected-instruction FIFO (power of two, 2..16).
REQ-002 SHALL provide the following ports (name  direction  width  meaning):
- sysclk  in  1  sole clock, rising edge.
- sysreset  in  1  asynchronous, active-high reset.
- rom_code_in  in  16  word from the target code ROM.
- rom_code_ready  in  1  ROM word valid.
- tg_code_addr  in  16  target fetch address.
- tg_code_in  out  16  word delivered to the target.
- tg_code_ready  out  1  delivered word valid; the target consumes one word per cycle while high.
- cmd_halt, cmd_run, cmd_step  in  1 each  single-cycle command pulses from the supervisor.
- inj_data  in  16  instruction word to inject.
- inj_valid  in  1  / inj_ready  out  1  injection push handshake.
- bp_addr  in  16 / bp_enable  in  1  breakpoint address and enable.
- halted  out  1  high in HALT.
- bp_hit  out  1  sticky breakpoint-hit flag.
- saved_addr  out  16  tg_code_addr captured on entry to HALT.
- inj_count  out  5  FIFO occupancy.

Function
REQ-003 SHALL implement states RUN, HALT, INJECT, STEP.
REQ-004 In RUN, the block SHALL drive tg_code_in=rom_code_in and tg_code_ready=rom_code_ready combinationally, with zero latency.
REQ-005 In HALT, the block SHALL drive tg_code_ready=0 and tg_code_in=0.
REQ-006 A cmd_halt pulse in RUN SHALL cause the following transitions:
- that cycle's output is still passed through;
- next state is HALT;
- saved_addr is loaded with that cycle's tg_code_addr.
REQ-007 In HALT with inj_count>0, the block SHALL go to INJECT on the next cycle.
REQ-008 In INJECT, the block SHALL drive tg_code_in=FIFO head and tg_code_ready=1, and SHALL pop one word per cycle.
REQ-009 The block SHALL leave INJECT for HALT in the cycle after the last word is popped.
REQ-010 In HALT with the FIFO empty, a cmd_step pulse SHALL move the block to STEP.
REQ-011 STEP SHALL pass the ROM through until exactly one cycle with rom_code_ready=1 has occurred, then return to HALT.
REQ-012 On leaving STEP, saved_addr SHALL be updated to the tg_code_addr of the cycle following the step word.
REQ-013 cmd_run in HALT SHALL move the block to RUN; cmd_run in INJECT or STEP SHALL be ignored.
REQ-014 cmd_step outside HALT SHALL be ignored.
REQ-015 cmd_halt outside RUN SHALL be ignored.
REQ-016 Simultaneous command pulses SHALL be prioritised cmd_halt > cmd_step > cmd_run.
REQ-017 The FIFO SHALL push when inj_valid && inj_ready, with inj_ready = (inj_count < INJ_DEPTH).
REQ-018 A push to a full FIFO SHALL be refused, with no overwrite.
REQ-019 A simultaneous push and pop SHALL leave inj_count unchanged.
REQ-020 FIFO pointers SHALL wrap modulo INJ_DEPTH.
REQ-021 Pushes SHALL be accepted in any state; popping SHALL occur only in INJECT.

Reset
REQ-022 sysreset SHALL asynchronously force the following, including mid-INJECT or mid-STEP:
- state=RUN, FIFO flushed (inj_count=0), halted=0, bp_hit=0, saved_addr=0;
- breakpoint skip flag cleared.
REQ-023 During reset, tg_code_ready SHALL be 0.
REQ-024 The first RUN pass-through SHALL occur in the first clock after sysreset deasserts.

Configuration
REQ-025 With VISOR_BREAKPOINT_EN defined, a RUN cycle with bp_enable=1, rom_code_ready=1, tg_code_addr==bp_addr and the skip flag clear SHALL:
- force tg_code_ready=0 for that cycle;
- enter HALT;
- set saved_addr=bp_addr and bp_hit=1.
REQ-026 With VISOR_BREAKPOINT_EN defined, cmd_run or cmd_step from a breakpoint halt SHALL set the skip flag.
REQ-027 The skip flag SHALL clear after the first delivered ROM word, so the breakpoint does not retrigger at the same address.
REQ-028 bp_hit SHALL clear on cmd_run.
REQ-029 Without VISOR_BREAKPOINT_EN, bp_addr and bp_enable SHALL be ignored, bp_hit SHALL be tied 0, and no comparator logic SHALL be generated.

Structure
REQ-030 The state encodings (2-bit), the command priority constants and the INJ_DEPTH default SHALL live in the shared package visor_pkg, used by both visor and visor_code_gate.
REQ-031 The FIFO SHALL be a sub-module visor_inj_fifo with these ports:
- push/pop handshake;
- head data output;
- count output;
- asynchronous reset.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- Pass-through: RUN, rom_code_in=16'h1234, rom_code_ready=1 -> tg_code_in=16'h1234, tg_code_ready=1 in the same cycle.
- Halt/inject: cmd_halt at tg_code_addr=16'h0040, then push 16'hA001, 16'hA002, 16'hA003 -> saved_addr=16'h0040; three consecutive tg_code_ready=1 cycles carrying A001, A002, A003; halted=1 afterwards.
- FIFO full: push 5 words with INJ_DEPTH=4 while halted at a step boundary -> the 5th push sees inj_ready=0; inj_count=4; 4 words injected; the 5th is never delivered.
- Step: HALT with rom_code_ready low for 2 cycles, then high for 1 cycle -> exactly one word delivered, then HALT; cmd_run the same cycle as cmd_step -> step taken.
- Breakpoint (macro on): bp_addr=16'h0100, bp_enable=1, fetch reaches 16'h0100 -> tg_code_ready=0, halted=1, bp_hit=1; after cmd_run, the word at 16'h0100 is delivered once with no retrigger.
- Reset mid-INJECT: assert sysreset with 2 words queued -> inj_count=0, RUN, tg_code_ready=0 during reset.

Source files
------------

// File: rtl/visor_pkg.sv
// visor_pkg: shared state and command encodings plus the default injection
// FIFO depth, used by visor and visor_code_gate.
package visor_pkg;

  localparam int unsigned INJ_DEPTH_DEFAULT = 4;

  // Gate operating modes (2-bit encoding).
  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_HALT   = 2'b01,
    ST_INJECT = 2'b10,
    ST_STEP   = 2'b11
  } visor_state_e;

  // Supervisor commands; the encoded value is the priority, higher wins
  // when pulses coincide (halt > step > run).
  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_RUN  = 2'd1,
    CMD_STEP = 2'd2,
    CMD_HALT = 2'd3
  } visor_cmd_e;

  // Pick the single command that applies in the given state. Commands that
  // the state ignores are dropped before priority is applied, so an ignored
  // halt never masks a step or run.
  function automatic visor_cmd_e visor_cmd_select(
    input visor_state_e st,
    input logic         halt,
    input logic         step,
    input logic         run
  );
    visor_cmd_e sel;
    sel = CMD_NONE;
    case (st)
      ST_RUN: begin
        if (halt) sel = CMD_HALT;
      end
      ST_HALT: begin
        if (step)     sel = CMD_STEP;
        else if (run) sel = CMD_RUN;
      end
      default: sel = CMD_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/visor_inj_fifo.sv
// visor_inj_fifo: circular buffer holding supervisor-injected instruction
// words. Push is refused when full; pop is ignored when empty.
module visor_inj_fifo
  import visor_pkg::*;
#(
  parameter int unsigned DEPTH = INJ_DEPTH_DEFAULT,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_valid_i,
  output logic             push_ready_o,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [4:0]       count_o
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]  DEPTH_C = 5'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [4:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign push_ready_o = (count_q < DEPTH_C);
  assign head_o       = mem_q[rd_ptr_q];
  assign count_o      = count_q;

  // Handshake qualification and next pointer/occupancy values; pointers
  // wrap naturally because DEPTH is a power of two.
  always_comb begin
    do_push  = push_valid_i && push_ready_o;
    do_pop   = pop_i && (count_q != '0);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset flushes the buffer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/visor_code_gate.sv
// visor_code_gate: sits between the target code ROM and the target fetch
// port. Passes ROM words through while running, blocks them while halted,
// feeds supervisor-injected words from a FIFO, and single-steps on request.
// Optional breakpoint support is compiled in with VISOR_BREAKPOINT_EN.
module visor_code_gate
  import visor_pkg::*;
#(
  parameter int unsigned INJ_DEPTH = INJ_DEPTH_DEFAULT
) (
  input  logic        sysclk,
  input  logic        sysreset,
  input  logic [15:0] rom_code_in,
  input  logic        rom_code_ready,
  input  logic [15:0] tg_code_addr,
  output logic [15:0] tg_code_in,
  output logic        tg_code_ready,
  input  logic        cmd_halt,
  input  logic        cmd_run,
  input  logic        cmd_step,
  input  logic [15:0] inj_data,
  input  logic        inj_valid,
  output logic        inj_ready,
  input  logic [15:0] bp_addr,
  input  logic        bp_enable,
  output logic        halted,
  output logic        bp_hit,
  output logic [15:0] saved_addr,
  output logic [4:0]  inj_count
);

  visor_state_e state_q;
  logic         halted_q;
  logic [15:0]  saved_addr_q;
  logic         step_cap_q;

  visor_cmd_e   cmd;
  logic         halt_empty;
  logic         go_step, go_run;
  logic         push_acc;
  logic         fifo_pop;
  logic [15:0]  fifo_head;
  logic         bp_trip;

  visor_inj_fifo #(
    .DEPTH (INJ_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk_i        (sysclk),
    .rst_i        (sysreset),
    .push_valid_i (inj_valid),
    .push_ready_o (inj_ready),
    .push_data_i  (inj_data),
    .pop_i        (fifo_pop),
    .head_o       (fifo_head),
    .count_o      (inj_count)
  );

  assign halted     = halted_q;
  assign saved_addr = saved_addr_q;
  assign push_acc   = inj_valid && inj_ready;

  // Command decode; leaving HALT on a command requires an empty FIFO, since
  // queued injections always take precedence.
  always_comb begin
    cmd        = visor_cmd_select(state_q, cmd_halt, cmd_step, cmd_run);
    halt_empty = (state_q == ST_HALT) && (inj_count == '0);
    go_step    = halt_empty && (cmd == CMD_STEP);
    go_run     = halt_empty && (cmd == CMD_RUN);
  end

  // Zero-latency output mux toward the target; nothing is offered in reset.
  always_comb begin
    tg_code_in    = '0;
    tg_code_ready = 1'b0;
    fifo_pop      = 1'b0;
    if (!sysreset) begin
      case (state_q)
        ST_RUN: begin
          tg_code_in    = rom_code_in;
          tg_code_ready = rom_code_ready && !bp_trip;
        end
        ST_STEP: begin
          tg_code_in    = rom_code_in;
          tg_code_ready = rom_code_ready;
        end
        ST_INJECT: begin
          tg_code_in    = fifo_head;
          tg_code_ready = 1'b1;
          fifo_pop      = 1'b1;
        end
        default: begin
          tg_code_in    = '0;
          tg_code_ready = 1'b0;
        end
      endcase
    end
  end

  // Mode sequencer with registered halted flag and saved fetch address.
  // After a step word, the address is captured one cycle later (the fetch
  // address following the stepped word), independent of the mode then.
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      state_q      <= ST_RUN;
      halted_q     <= 1'b0;
      saved_addr_q <= '0;
      step_cap_q   <= 1'b0;
    end else begin
      step_cap_q <= 1'b0;
      if (step_cap_q) saved_addr_q <= tg_code_addr;
      case (state_q)
        ST_RUN: begin
          if (bp_trip || (cmd == CMD_HALT)) begin
            state_q      <= ST_HALT;
            halted_q     <= 1'b1;
            saved_addr_q <= tg_code_addr;
          end
        end
        ST_HALT: begin
          if (inj_count != '0) begin
            state_q  <= ST_INJECT;
            halted_q <= 1'b0;
          end else if (go_step) begin
            state_q  <= ST_STEP;
            halted_q <= 1'b0;
          end else if (go_run) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
          end
        end
        ST_INJECT: begin
          if ((inj_count == 5'd1) && !push_acc) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end
        end
        ST_STEP: begin
          if (rom_code_ready) begin
            state_q    <= ST_HALT;
            halted_q   <= 1'b1;
            step_cap_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= ST_RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef VISOR_BREAKPOINT_EN
  logic bp_hit_q;
  logic bp_halt_q;
  logic skip_q;
  logic rom_taken;

  assign bp_trip   = (state_q == ST_RUN) && bp_enable && rom_code_ready &&
                     (tg_code_addr == bp_addr) && !skip_q;
  assign rom_taken = ((state_q == ST_RUN) || (state_q == ST_STEP)) && tg_code_ready;
  assign bp_hit    = bp_hit_q;

  // Breakpoint bookkeeping: sticky hit flag, a marker that the current halt
  // came from a breakpoint, and a one-word skip so resuming does not
  // immediately retrigger on the same address.
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      bp_hit_q  <= 1'b0;
      bp_halt_q <= 1'b0;
      skip_q    <= 1'b0;
    end else begin
      if (rom_taken) skip_q <= 1'b0;
      if (bp_trip) begin
        bp_hit_q  <= 1'b1;
        bp_halt_q <= 1'b1;
      end else if (go_step || go_run) begin
        bp_halt_q <= 1'b0;
        if (bp_halt_q) skip_q <= 1'b1;
        if (go_run) bp_hit_q <= 1'b0;
      end
    end
  end
`else
  logic unused_bp;
  assign unused_bp = ^{bp_addr, bp_enable};
  assign bp_trip   = 1'b0;
  assign bp_hit    = 1'b0;
`endif

endmodule
